// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending (busy) tracking for in-order issue scoreboarding.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module scoreboard_regfile #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rdReg1,
  input  logic [AW-1:0]    rdReg2,
  output logic [WIDTH-1:0] rdData1,
  output logic [WIDTH-1:0] rdData2,
  output logic             rdBusy1,
  output logic             rdBusy2,
  input  logic             issue,
  input  logic [AW-1:0]    issueReg,
  input  logic             write,
  input  logic [AW-1:0]    wrReg,
  input  logic [WIDTH-1:0] wrData,
  output logic [AW:0]      pendCount,
  output logic             wrOrphan
);

  localparam bit ZeroEn = (ZERO_REG != 0);
  localparam logic [AW:0] MaxPend = (AW+1)'(DEPTH);
  localparam logic [AW:0] OnePend = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      pend_q, pend_d;
  logic             orphan_q, orphan_d;

  logic wr_en, is_en, same_reg, pend_inc, pend_dec;

  // Register 0 swallows writes and issues when hardwired to zero.
  assign wr_en    = write && !(ZeroEn && (wrReg == '0));
  assign is_en    = issue && !(ZeroEn && (issueReg == '0));
  assign same_reg = (issueReg == wrReg);

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wrReg] = 1'b0;
    // Issue is applied after the write so a same-edge re-issue keeps the bit set.
    if (is_en) busy_d[issueReg] = 1'b1;
  end

  always_comb begin
    pend_inc = is_en && !busy_q[issueReg];
    pend_dec = wr_en && busy_q[wrReg] && !(is_en && same_reg);
    pend_d   = pend_q;
    if (pend_inc && !pend_dec && (pend_q != MaxPend)) begin
      pend_d = pend_q + OnePend;
    end else if (pend_dec && !pend_inc && (pend_q != '0)) begin
      pend_d = pend_q - OnePend;
    end
  end

  assign orphan_d = wr_en && !busy_q[wrReg];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      busy_q   <= '0;
      pend_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wrReg] <= wrData;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      orphan_q <= orphan_d;
    end
  end

  always_comb begin
    rdData1 = mem_q[rdReg1];
    rdBusy1 = busy_q[rdReg1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wrReg == rdReg1)) begin
      rdData1 = wrData;
      rdBusy1 = is_en && (issueReg == rdReg1);
    end
`endif
    if (ZeroEn && (rdReg1 == '0)) begin
      rdData1 = '0;
      rdBusy1 = 1'b0;
    end
  end

  always_comb begin
    rdData2 = mem_q[rdReg2];
    rdBusy2 = busy_q[rdReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wrReg == rdReg2)) begin
      rdData2 = wrData;
      rdBusy2 = is_en && (issueReg == rdReg2);
    end
`endif
    if (ZeroEn && (rdReg2 == '0)) begin
      rdData2 = '0;
      rdBusy2 = 1'b0;
    end
  end

  assign pendCount = pend_q;
  assign wrOrphan  = orphan_q;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile; expectations queued at drive time, popped at sample time.
module tb_scoreboard_regfile;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    rdReg1, rdReg2, issueReg, wrReg;
  logic [WIDTH-1:0] rdData1, rdData2, wrData;
  logic             rdBusy1, rdBusy2, issue, write, wrOrphan;
  logic [AW:0]      pendCount;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  scoreboard_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rdReg1(rdReg1), .rdReg2(rdReg2), .rdData1(rdData1), .rdData2(rdData2),
    .rdBusy1(rdBusy1), .rdBusy2(rdBusy2),
    .issue(issue), .issueReg(issueReg),
    .write(write), .wrReg(wrReg), .wrData(wrData),
    .pendCount(pendCount), .wrOrphan(wrOrphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h required=<queued entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; issue = 1'b0; write = 1'b0;
    rdReg1 = '0; rdReg2 = '0; issueReg = '0; wrReg = '0; wrData = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state across every address.
    expect_val("rst_pend", 0);
    expect_val("rst_orphan", 0);
    #1;
    check(64'(pendCount));
    check(64'(wrOrphan));
    for (int i = 0; i < DEPTH; i++) begin
      rdReg1 = AW'(i);
      rdReg2 = AW'(DEPTH - 1 - i);
      expect_val("rst_data1", 0);
      expect_val("rst_busy1", 0);
      expect_val("rst_data2", 0);
      expect_val("rst_busy2", 0);
      #1;
      check(64'(rdData1));
      check(64'(rdBusy1));
      check(64'(rdData2));
      check(64'(rdBusy2));
    end

    // Issue 5, then complete it.
    issue = 1'b1; issueReg = 5'd5;
    tick();
    issue = 1'b0; rdReg1 = 5'd5;
    expect_val("iss5_busy", 1);
    expect_val("iss5_pend", 1);
    #1;
    check(64'(rdBusy1));
    check(64'(pendCount));
    write = 1'b1; wrReg = 5'd5; wrData = 32'hDEADBEEF;
    tick();
    write = 1'b0;
    expect_val("wr5_data", 64'hDEADBEEF);
    expect_val("wr5_busy", 0);
    expect_val("wr5_pend", 0);
    expect_val("wr5_orphan", 0);
    #1;
    check(64'(rdData1));
    check(64'(rdBusy1));
    check(64'(pendCount));
    check(64'(wrOrphan));

    // Same-edge issue and write to 7: newer issue wins.
    issue = 1'b1; issueReg = 5'd7; write = 1'b1; wrReg = 5'd7; wrData = 32'h12;
    tick();
    issue = 1'b0; write = 1'b0; rdReg1 = 5'd7;
    expect_val("iw7_data", 64'h12);
    expect_val("iw7_busy", 1);
    expect_val("iw7_pend", 1);
    expect_val("iw7_orphan", 1);
    #1;
    check(64'(rdData1));
    check(64'(rdBusy1));
    check(64'(pendCount));
    check(64'(wrOrphan));

    // Orphan write to idle register 3 pulses for exactly one cycle.
    write = 1'b1; wrReg = 5'd3; wrData = 32'h33;
    tick();
    write = 1'b0;
    expect_val("orph3_pulse", 1);
    #1;
    check(64'(wrOrphan));
    tick();
    expect_val("orph3_clear", 0);
    #1;
    check(64'(wrOrphan));

    // Re-issue of an already-busy register leaves the count alone.
    issue = 1'b1; issueReg = 5'd7;
    tick();
    issue = 1'b0;
    expect_val("reiss7_busy", 1);
    expect_val("reiss7_pend", 1);
    #1;
    check(64'(rdBusy1));
    check(64'(pendCount));
    write = 1'b1; wrReg = 5'd7; wrData = 32'h77;
    tick();
    write = 1'b0;
    expect_val("wr7_pend", 0);
    expect_val("wr7_orphan", 0);
    #1;
    check(64'(pendCount));
    check(64'(wrOrphan));

    // Issue 10 while writing idle 11: independent +1 and orphan.
    issue = 1'b1; issueReg = 5'd10; write = 1'b1; wrReg = 5'd11; wrData = 32'hB;
    tick();
    issue = 1'b0; write = 1'b0;
    expect_val("mix_pend", 1);
    expect_val("mix_orphan", 1);
    #1;
    check(64'(pendCount));
    check(64'(wrOrphan));
    write = 1'b1; wrReg = 5'd10; wrData = 32'hA;
    tick();
    write = 1'b0;
    expect_val("mix_clr_pend", 0);
    #1;
    check(64'(pendCount));

    // Register 0 ignores everything.
    issue = 1'b1; issueReg = '0; write = 1'b1; wrReg = '0; wrData = 32'hFFFFFFFF; rdReg1 = '0;
    expect_val("z_data_pre", 0);
    expect_val("z_busy_pre", 0);
    #1;
    check(64'(rdData1));
    check(64'(rdBusy1));
    tick();
    issue = 1'b0; write = 1'b0;
    expect_val("z_data", 0);
    expect_val("z_busy", 0);
    expect_val("z_pend", 0);
    expect_val("z_orphan", 0);
    #1;
    check(64'(rdData1));
    check(64'(rdBusy1));
    check(64'(pendCount));
    check(64'(wrOrphan));

    // Read-during-write on reg 9: forwarded only with bypass.
    write = 1'b1; wrReg = 5'd9; wrData = 32'hA5A5A5A5; rdReg2 = 5'd9;
    expect_val("rdw9_pre", Bypass ? 64'hA5A5A5A5 : 64'h0);
    #1;
    check(64'(rdData2));
    tick();
    write = 1'b0;
    expect_val("rdw9_post", 64'hA5A5A5A5);
    #1;
    check(64'(rdData2));

    // Same-cycle issue+write on the read address.
    issue = 1'b1; issueReg = 5'd9; write = 1'b1; wrReg = 5'd9; wrData = 32'h5A;
    expect_val("iw9_data_pre", Bypass ? 64'h5A : 64'hA5A5A5A5);
    expect_val("iw9_busy_pre", Bypass ? 64'h1 : 64'h0);
    #1;
    check(64'(rdData2));
    check(64'(rdBusy2));
    tick();
    issue = 1'b0; write = 1'b0;
    expect_val("iw9_busy", 1);
    expect_val("iw9_pend", 1);
    #1;
    check(64'(rdBusy2));
    check(64'(pendCount));
    write = 1'b1; wrReg = 5'd9; wrData = 32'h99;
    tick();
    write = 1'b0;
    expect_val("wr9_pend", 0);
    #1;
    check(64'(pendCount));

    // Fill every nonzero register, then reset with a write in flight.
    for (int i = 1; i < DEPTH; i++) begin
      issue = 1'b1; issueReg = AW'(i);
      tick();
    end
    issue = 1'b0;
    rdReg1 = 5'd31;
    expect_val("full_pend", DEPTH - 1);
    expect_val("full_busy31", 1);
    #1;
    check(64'(pendCount));
    check(64'(rdBusy1));
    reset = 1'b1; write = 1'b1; wrReg = 5'd4; wrData = 32'hCAFEF00D;
    tick();
    reset = 1'b0; write = 1'b0;
    expect_val("rr_pend", 0);
    expect_val("rr_orphan", 0);
    #1;
    check(64'(pendCount));
    check(64'(wrOrphan));
    for (int i = 0; i < DEPTH; i++) begin
      rdReg1 = AW'(i);
      expect_val("rr_busy", 0);
      expect_val("rr_data", 0);
      #1;
      check(64'(rdBusy1));
      check(64'(rdData1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of registers (power of two, >=2); AW = log2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and ignores writes/issues.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rdReg1, rdReg2  input  AW  read addresses.
REQ-007 rdData1, rdData2  output  WIDTH  read data.
REQ-008 rdBusy1, rdBusy2  output  1  addressed register has a pending (issued, not yet written) result.
REQ-009 issue  input  1  mark issueReg pending at next edge.
REQ-010 issueReg  input  AW  destination being issued.
REQ-011 write  input  1  write wrData to wrReg at next edge, clearing its pending bit.
REQ-012 wrReg  input  AW  write address.
REQ-013 wrData  input  WIDTH  write data.
REQ-014 pendCount  output  AW+1  number of registers currently pending.
REQ-015 wrOrphan  output  1  registered flag: previous cycle wrote a register that was not pending.

Function
REQ-016 Storage: DEPTH x WIDTH array plus DEPTH-bit busy vector, both synchronous-write.
REQ-017 Reads combinational: rdDataN = array[rdRegN], rdBusyN = busy[rdRegN] (bypass see REQ-028).
REQ-018 Write: when write=1, array[wrReg] <= wrData at the edge; busy[wrReg] <= 0 unless REQ-020 applies.
REQ-019 Issue: when issue=1, busy[issueReg] <= 1 at the edge.
REQ-020 Same edge issue=1 and write=1 with issueReg==wrReg: data written, busy bit ends 1 (newer issue wins).
REQ-021 ZERO_REG=1: address 0 reads rdData=0, rdBusy=0; writes and issues to 0 have no effect and never count.
REQ-022 pendCount tracks popcount of busy: +1 on set of a clear bit, -1 on clear of a set bit, net per edge; never wraps (max DEPTH, min 0).
REQ-023 Re-issuing an already-busy register leaves busy=1 and pendCount unchanged.
REQ-024 wrOrphan <= write && !busy[wrReg] && !(ZERO_REG && wrReg==0), evaluated on pre-edge state; 1-cycle pulse, no effect on data.
REQ-025 Read and write to same address in one cycle without bypass: rdData shows old value until the edge.

Reset
REQ-026 reset=1 at edge: all array entries 0, busy vector 0, pendCount 0, wrOrphan 0; overrides write and issue that cycle.
REQ-027 Reset asserted mid-operation discards all pending state; no partial update of any register.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: if write=1 and wrReg==rdRegN (not zero reg), rdDataN=wrData and rdBusyN=0 unless issue=1 to the same register that cycle (then rdBusyN=1); combinational same-cycle forwarding.
REQ-029 Macro REGFILE_BYPASS_EN undefined: no forwarding; reads reflect stored state only (REQ-017, REQ-025).

Verification
REQ-030 Reset then read all addresses -> rdData=0, rdBusy=0, pendCount=0, wrOrphan=0.
REQ-031 issue reg 5; next cycle rdReg1=5 -> rdBusy1=1, pendCount=1; write reg 5 data 0xDEADBEEF -> after edge rdData1=0xDEADBEEF, rdBusy1=0, pendCount=0, wrOrphan=0.
REQ-032 Same cycle issue 7 and write 7 data 0x12 -> after edge data 0x12, busy[7]=1, pendCount=1; write 3 (not busy) -> wrOrphan=1 for one cycle.
REQ-033 Issue/write/read reg 0 with data 0xFFFFFFFF (ZERO_REG=1) -> rdData=0, rdBusy=0, pendCount=0, wrOrphan=0.
REQ-034 write reg 9 data 0xA5A5A5A5 with rdReg2=9 same cycle -> with REGFILE_BYPASS_EN rdData2=0xA5A5A5A5 before edge; without, old value (0) until edge.
REQ-035 Issue all DEPTH-1 nonzero regs, assert reset with write=1 -> after edge pendCount=0, all busy 0, no register written.
